updn_button_ctrl: RTL and testbench
===================================

Name: updn_button_ctrl

Overview:
- Upstream control stage for the 4-bit up/down counter: converts two raw push-buttons (up, down) into a stable direction level UD and a single-cycle count-step pulse STEP.
- Provides synchronisation, debounce, press arbitration and one step per press, so the counter advances exactly once per clean press.
- UD=1 means count up; UD=0 means count down.

Parameters:
- DEB_CYCLES, 4, consecutive cycles a synchronised input must differ from its debounced level before that level toggles (legal 2..255).
- DEB_W, 8, width of each debounce counter; must hold DEB_CYCLES.
- HOLD_CYCLES, 16, auto-repeat initial delay (used only with UPDN_AUTO_REPEAT_EN).
- REPEAT_CYCLES, 8, auto-repeat period (used only with UPDN_AUTO_REPEAT_EN).

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RESETN  input  1  asynchronous, active-low reset.
- BTN_UP  input  1  raw up button, active high, asynchronous to CLK.
- BTN_DN  input  1  raw down button, active high, asynchronous to CLK.
- UD  output  1  registered direction to the counter; 1 = up.
- STEP  output  1  registered one-cycle count-enable pulse.

Behaviour:
- Reset: one clock, CLK; reset is asynchronous and active-low, on RESETN. While RESETN=0: UD=0, STEP=0, FSM=IDLE, both synchroniser flops=0, debounced levels=0, all counters=0. Takes effect immediately without a clock edge, including mid-press or mid-pulse. Release is honoured at the next edge.
- Synchroniser: 2 flops per button (s1, s2).
- Debounce, per button:
  - Counter increments each edge while s2 != deb; clears on any edge where s2 == deb.
  - When the count reaches DEB_CYCLES, deb toggles on that edge and the counter clears.
  - Pulses shorter than DEB_CYCLES cycles never change deb.
- Latency: raw input steady from before edge 0 -> s2 valid after edge 1 -> deb toggles at edge DEB_CYCLES+1.
- FSM states IDLE, ARM, HOLD:
  - IDLE: up_deb & ~dn_deb -> ARM, UD<=1, act<=UP. dn_deb & ~up_deb -> ARM, UD<=0, act<=DN. Both high or both low -> stay, UD unchanged.
  - ARM: STEP=1 for exactly this cycle -> HOLD unconditionally. UD is already stable in the cycle STEP is high.
  - HOLD: STEP=0. Return to IDLE when the deb level of the active button is 0. The other button is ignored while in HOLD.
- Press-to-step latency: deb rises at edge N -> UD updates at edge N+1 -> STEP high from edge N+1 to N+2. Total STEP assertion at edge DEB_CYCLES+2 after the raw edge is captured.
- Simultaneous presses (both deb levels rise on the same edge): no STEP, UD unchanged. The FSM waits in IDLE until exactly one level is high.
- Second button pressed while the first is held: ignored. If the first is released while the second is still held, the second is accepted as a new press from IDLE (one STEP).
- UD holds its last value indefinitely; it changes only on the IDLE->ARM transition.
- STEP is never high on two consecutive cycles.

Optional Feature:
- Macro: UPDN_AUTO_REPEAT_EN.
- Defined:
  - A repeat counter clears on entry to HOLD.
  - After HOLD_CYCLES cycles in HOLD with the active button still debounced high, FSM goes to ARM (one STEP, UD unchanged) and returns to HOLD.
  - Later repeats occur every REPEAT_CYCLES cycles (HOLD entry to next ARM) while the button is held.
  - Release clears the counter and returns the FSM to IDLE.
- Undefined: repeat logic absent; exactly one STEP per accepted press however long it is held.

Test Plan:
- Reset: assert RESETN=0 mid-run with BTN_UP=1 -> UD=0 and STEP=0 immediately without a clock edge. Release with BTN_UP held -> single STEP at edge 6 after release (DEB_CYCLES=4), UD=1.
- Clean up press: BTN_UP=1 from edge 0 for 20 cycles -> deb at edge 5, UD=1 at edge 6, STEP=1 only in cycle edge 6..7, no further STEP. Then BTN_DN press -> UD=0 and one STEP.
- Bounce: BTN_UP toggled 1,0,1,0 every 2 cycles, then held -> no STEP during bounce; exactly one STEP DEB_CYCLES+2 edges after the last stable transition.
- Simultaneous: BTN_UP and BTN_DN rise on the same edge and are held 20 cycles -> STEP stays 0, UD unchanged. Release BTN_DN -> one STEP, UD=1.
- Overlap: hold BTN_UP, press BTN_DN during HOLD -> no STEP. Release BTN_UP while BTN_DN is held -> one STEP with UD=0.
- Auto-repeat (macro defined): hold BTN_UP 60 cycles -> STEPs at edge 6, then 16 cycles after HOLD entry, then every 8 cycles. Macro undefined -> exactly 1 STEP.

Source files
------------

// File: rtl/updn_button_ctrl.sv
// Turns two raw up/down push-buttons into a stable direction level (UD) and a one-cycle STEP per clean press.
// Optional auto-repeat while a button is held: define UPDN_AUTO_REPEAT_EN.
module updn_button_ctrl #(
   parameter int DEB_CYCLES    = 4,
   parameter int DEB_W         = 8,
   parameter int HOLD_CYCLES   = 16,
   parameter int REPEAT_CYCLES = 8
) (
   input  logic CLK,
   input  logic RESETN,
   input  logic BTN_UP,
   input  logic BTN_DN,
   output logic UD,
   output logic STEP
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ARM  = 2'd1;
   localparam logic [1:0] HOLD = 2'd2;

   if (DEB_CYCLES < 2 || DEB_CYCLES > 255 || DEB_CYCLES >= (1 << DEB_W)
       || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_param_check
      $error("updn_button_ctrl: illegal parameter set");
   end

   // Bit 0 carries the up button, bit 1 the down button throughout.
   logic [1:0] raw;
   logic [1:0] s1;
   logic [1:0] s2;
   logic [1:0] deb;

   assign raw = {BTN_DN, BTN_UP};

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= raw;
         s2 <= s1;
      end
   end

   for (genvar i = 0; i < 2; i++) begin : g_deb
      logic [DEB_W-1:0] cnt;
      logic             lvl;

      // Level flips only after DEB_CYCLES consecutive disagreeing samples.
      always_ff @(posedge CLK or negedge RESETN) begin
         if (!RESETN) begin
            cnt <= '0;
            lvl <= 1'b0;
         end else if (s2[i] == lvl) begin
            cnt <= '0;
         end else if (cnt == DEB_W'(DEB_CYCLES - 1)) begin
            cnt <= '0;
            lvl <= ~lvl;
         end else begin
            cnt <= cnt + DEB_W'(1);
         end
      end

      assign deb[i] = lvl;
   end

   logic [1:0] state;
   logic [1:0] state_nx;
   logic       act;
   logic       act_nx;
   logic       ud_nx;
   logic       act_deb;

   // act=1: the up button owns the current press.
   assign act_deb = act ? deb[0] : deb[1];

`ifdef UPDN_AUTO_REPEAT_EN
   localparam int REP_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int REP_W   = $clog2(REP_MAX + 1);

   logic [REP_W-1:0] rep_cnt;
   logic             rep_first;
   logic             rep_due;

   assign rep_due = (rep_cnt == (rep_first ? REP_W'(HOLD_CYCLES - 1)
                                           : REP_W'(REPEAT_CYCLES - 1)));
`endif

   always_comb begin
      state_nx = state;
      act_nx   = act;
      ud_nx    = UD;
      case (state)
         IDLE: begin
            if (deb[0] && !deb[1]) begin
               state_nx = ARM;
               act_nx   = 1'b1;
               ud_nx    = 1'b1;
            end else if (deb[1] && !deb[0]) begin
               state_nx = ARM;
               act_nx   = 1'b0;
               ud_nx    = 1'b0;
            end
         end
         ARM:  state_nx = HOLD;
         HOLD: begin
            if (!act_deb) begin
               state_nx = IDLE;
            end
`ifdef UPDN_AUTO_REPEAT_EN
            else if (rep_due) begin
               state_nx = ARM;
            end
`endif
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state <= IDLE;
         act   <= 1'b0;
         UD    <= 1'b0;
         STEP  <= 1'b0;
      end else begin
         state <= state_nx;
         act   <= act_nx;
         UD    <= ud_nx;
         STEP  <= (state_nx == ARM);
      end
   end

`ifdef UPDN_AUTO_REPEAT_EN
   // Counter runs only while staying in HOLD; any exit or fresh entry restarts it.
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         rep_cnt   <= '0;
         rep_first <= 1'b0;
      end else begin
         if (state != HOLD || state_nx != HOLD) begin
            rep_cnt <= '0;
         end else begin
            rep_cnt <= rep_cnt + REP_W'(1);
         end
         if (state == IDLE && state_nx == ARM) begin
            rep_first <= 1'b1;
         end else if (state == HOLD && state_nx == ARM) begin
            rep_first <= 1'b0;
         end
      end
   end
`endif

endmodule

// File: tb/tb_updn_button_ctrl.sv
// Directed bench for updn_button_ctrl (default build, DEB_CYCLES=4): expected STEP events are
// queued when a press is driven and matched against the DUT when STEP appears.
module tb_updn_button_ctrl;

   logic CLK = 1'b0;
   logic RESETN;
   logic BTN_UP;
   logic BTN_DN;
   logic UD;
   logic STEP;

   int checks   = 0;
   int failures = 0;
   int edge_n   = 0;
   logic prev_step = 1'b0;

   typedef struct {
      int   cyc;
      logic ud;
   } exp_t;

   exp_t sb[$];

   updn_button_ctrl dut (
      .CLK   (CLK),
      .RESETN(RESETN),
      .BTN_UP(BTN_UP),
      .BTN_DN(BTN_DN),
      .UD    (UD),
      .STEP  (STEP)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) edge_n <= edge_n + 1;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0d expected=%0d (edge %0d)", tag, obs, exp, edge_n);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge CLK);
   endtask

   // A press driven now (mid-cycle) produces STEP visible 'lat' negedges later.
   task automatic push(input int lat, input logic ud);
      exp_t e;
      e.cyc = edge_n + lat;
      e.ud  = ud;
      sb.push_back(e);
   endtask

   always @(negedge CLK) begin
      exp_t e;
      if (STEP === 1'b1) begin
         chk("step_not_consecutive", int'(prev_step), 0);
         chk("step_expected", int'(sb.size() > 0), 1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("step_edge", edge_n, e.cyc);
            chk("step_ud", int'(UD), int'(e.ud));
         end
      end
      prev_step = STEP;
   end

   initial begin
      RESETN = 1'b0;
      BTN_UP = 1'b0;
      BTN_DN = 1'b0;
      #1;
      chk("reset_ud", int'(UD), 0);
      chk("reset_step", int'(STEP), 0);
      wait_cyc(3);
      RESETN = 1'b1;
      wait_cyc(2);

      // clean up press, then clean down press
      BTN_UP = 1'b1;
      push(7, 1'b1);
      wait_cyc(20);
      BTN_UP = 1'b0;
      wait_cyc(12);
      chk("up_sb_empty", sb.size(), 0);
      BTN_DN = 1'b1;
      push(7, 1'b0);
      wait_cyc(20);
      BTN_DN = 1'b0;
      wait_cyc(12);
      chk("dn_sb_empty", sb.size(), 0);

      // simultaneous press: nothing until down is released
      BTN_UP = 1'b1;
      BTN_DN = 1'b1;
      wait_cyc(20);
      chk("sim_ud_unchanged", int'(UD), 0);
      chk("sim_sb_empty", sb.size(), 0);
      BTN_DN = 1'b0;
      push(7, 1'b1);
      wait_cyc(12);
      BTN_UP = 1'b0;
      wait_cyc(12);
      chk("sim_rel_sb_empty", sb.size(), 0);

      // overlap: down during up's hold is ignored, accepted after up releases
      BTN_UP = 1'b1;
      push(7, 1'b1);
      wait_cyc(12);
      BTN_DN = 1'b1;
      wait_cyc(20);
      chk("ovl_hold_sb_empty", sb.size(), 0);
      chk("ovl_hold_ud", int'(UD), 1);
      BTN_UP = 1'b0;
      push(8, 1'b0);
      wait_cyc(14);
      BTN_DN = 1'b0;
      wait_cyc(12);
      chk("ovl_sb_empty", sb.size(), 0);
      chk("ovl_ud", int'(UD), 0);

      // bounce 1,0,1,0 every 2 cycles, then held
      BTN_UP = 1'b1; wait_cyc(2);
      BTN_UP = 1'b0; wait_cyc(2);
      BTN_UP = 1'b1; wait_cyc(2);
      BTN_UP = 1'b0; wait_cyc(2);
      chk("bounce_no_step", sb.size(), 0);
      BTN_UP = 1'b1;
      push(7, 1'b1);
      wait_cyc(20);
      BTN_UP = 1'b0;
      wait_cyc(12);
      chk("bounce_sb_empty", sb.size(), 0);

      // reset asserted during the STEP pulse, released with the button still held
      BTN_UP = 1'b1;
      push(7, 1'b1);
      wait_cyc(7);
      #2;
      RESETN = 1'b0;
      #1;
      chk("midrst_ud", int'(UD), 0);
      chk("midrst_step", int'(STEP), 0);
      wait_cyc(2);
      RESETN = 1'b1;
      push(7, 1'b1);
      wait_cyc(20);
      BTN_UP = 1'b0;
      wait_cyc(12);
      chk("rst_rel_sb_empty", sb.size(), 0);
      chk("final_ud", int'(UD), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
